// File: rtl/btle_rx_pdu_fifo.sv
// Packet FIFO behind the BLE RX core: speculatively buffers octets and commits whole frames on a good CRC.
// Define BTLE_RX_PDU_FIFO_KEEP_BAD_CRC_EN to also keep bad-CRC frames, tagged with crc_ok=0.
module btle_rx_pdu_fifo #(
  parameter int ADDR_WIDTH      = 8,
  parameter int FRAME_PTR_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hit_flag,
  input  logic [7:0]               octet,
  input  logic                     octet_valid,
  input  logic                     decode_end,
  input  logic                     crc_ok,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  output logic                     m_last,
  output logic                     m_crc_ok,
  input  logic                     m_ready,
  output logic [FRAME_PTR_WIDTH:0] frame_count,
  output logic                     overflow_drop,
  output logic                     crc_drop
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int FDEPTH = 1 << FRAME_PTR_WIDTH;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_COLLECT = 2'd1;
  localparam logic [1:0] W_DROP    = 2'd2;

`ifdef BTLE_RX_PDU_FIFO_KEEP_BAD_CRC_EN
  localparam logic KEEP_BAD_CRC = 1'b1;
`else
  localparam logic KEEP_BAD_CRC = 1'b0;
`endif

  logic [7:0]            ram_q      [DEPTH];
  logic [ADDR_WIDTH:0]   desc_len_q [FDEPTH];
  logic                  desc_crc_q [FDEPTH];

  logic [1:0]                state_q, state_d;
  logic [ADDR_WIDTH:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]       spec_ptr_q, spec_ptr_d;
  logic [ADDR_WIDTH:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]       len_q, len_d;
  logic [ADDR_WIDTH:0]       rem_q, rem_d;
  logic                      loaded_q, loaded_d;
  logic [FRAME_PTR_WIDTH:0]  desc_wp_q, desc_wp_d;
  logic [FRAME_PTR_WIDTH:0]  desc_rp_q, desc_rp_d;
  logic                      overflow_drop_q, overflow_drop_d;
  logic                      crc_drop_q, crc_drop_d;

  logic [ADDR_WIDTH:0]       used, spec_inc, len_inc, cur_rem, head_len;
  logic [FRAME_PTR_WIDTH:0]  frame_cnt;
  logic                      ram_space, desc_full, avail, oct_acc, oct_full;
  logic                      push, push_crc, xfer, pop;

  // used never exceeds DEPTH, so its MSB alone flags a full RAM
  assign used      = spec_ptr_q - rd_ptr_q;
  assign ram_space = ~used[ADDR_WIDTH];
  assign frame_cnt = desc_wp_q - desc_rp_q;
  assign desc_full = frame_cnt[FRAME_PTR_WIDTH];
  assign avail     = |frame_cnt;
  assign head_len  = desc_len_q[desc_rp_q[FRAME_PTR_WIDTH-1:0]];
  assign cur_rem   = loaded_q ? rem_q : head_len;

  assign oct_acc  = (state_q == W_COLLECT) & octet_valid & ram_space & ~(hit_flag & ~decode_end);
  assign oct_full = (state_q == W_COLLECT) & octet_valid & ~ram_space;
  assign spec_inc = spec_ptr_q + {{ADDR_WIDTH{1'b0}}, oct_acc};
  assign len_inc  = len_q + {{ADDR_WIDTH{1'b0}}, oct_acc};

  assign m_valid       = avail;
  assign m_data        = avail ? ram_q[rd_ptr_q[ADDR_WIDTH-1:0]] : '0;
  assign m_crc_ok      = avail & desc_crc_q[desc_rp_q[FRAME_PTR_WIDTH-1:0]];
  assign m_last        = avail & (cur_rem == {{ADDR_WIDTH{1'b0}}, 1'b1});
  assign frame_count   = frame_cnt;
  assign overflow_drop = overflow_drop_q;
  assign crc_drop      = crc_drop_q;

  assign xfer = avail & m_ready;
  assign pop  = xfer & m_last;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    spec_ptr_d      = spec_ptr_q;
    len_d           = len_q;
    overflow_drop_d = 1'b0;
    crc_drop_d      = 1'b0;
    push            = 1'b0;
    push_crc        = 1'b0;
    case (state_q)
      W_COLLECT: begin
        if (decode_end) begin
          state_d = W_IDLE;
          if (oct_full) begin
            overflow_drop_d = 1'b1;
          end else if (len_inc != '0) begin
            if (crc_ok || KEEP_BAD_CRC) begin
              if (desc_full) begin
                overflow_drop_d = 1'b1;
              end else begin
                push     = 1'b1;
                push_crc = crc_ok;
                wr_ptr_d = spec_inc;
              end
            end else begin
              crc_drop_d = 1'b1;
            end
          end
        end else begin
          spec_ptr_d = spec_inc;
          len_d      = len_inc;
          if (oct_full) state_d = W_DROP;
        end
      end
      W_DROP: begin
        if (decode_end) begin
          overflow_drop_d = 1'b1;
          state_d         = W_IDLE;
        end
      end
      W_IDLE:  ;
      default: state_d = W_IDLE;
    endcase
    // A hit always (re)starts collection at the committed pointer, after any same-cycle commit
    if (hit_flag) begin
      state_d    = W_COLLECT;
      spec_ptr_d = wr_ptr_d;
      len_d      = '0;
    end
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, xfer};
    desc_rp_d = desc_rp_q + {{FRAME_PTR_WIDTH{1'b0}}, pop};
    desc_wp_d = desc_wp_q + {{FRAME_PTR_WIDTH{1'b0}}, push};
    loaded_d  = loaded_q;
    rem_d     = rem_q;
    if (xfer) begin
      loaded_d = ~m_last;
      rem_d    = cur_rem - {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= W_IDLE;
      wr_ptr_q        <= '0;
      spec_ptr_q      <= '0;
      rd_ptr_q        <= '0;
      len_q           <= '0;
      rem_q           <= '0;
      loaded_q        <= 1'b0;
      desc_wp_q       <= '0;
      desc_rp_q       <= '0;
      overflow_drop_q <= 1'b0;
      crc_drop_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      spec_ptr_q      <= spec_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      len_q           <= len_d;
      rem_q           <= rem_d;
      loaded_q        <= loaded_d;
      desc_wp_q       <= desc_wp_d;
      desc_rp_q       <= desc_rp_d;
      overflow_drop_q <= overflow_drop_d;
      crc_drop_q      <= crc_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (oct_acc) ram_q[spec_ptr_q[ADDR_WIDTH-1:0]] <= octet;
    if (push) begin
      desc_len_q[desc_wp_q[FRAME_PTR_WIDTH-1:0]] <= len_inc;
      desc_crc_q[desc_wp_q[FRAME_PTR_WIDTH-1:0]] <= push_crc;
    end
  end

endmodule

// File: tb/tb_btle_rx_pdu_fifo.sv
// Directed bench for btle_rx_pdu_fifo: a default-size instance and a 16-octet instance share one stimulus stream.
module tb_btle_rx_pdu_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit_flag = 1'b0;
  logic [7:0] octet = 8'h00;
  logic       octet_valid = 1'b0;
  logic       decode_end = 1'b0;
  logic       crc_ok = 1'b0;
  logic       m_ready = 1'b0;

  logic [7:0] m_data, m4_data;
  logic       m_valid, m_last, m_crc_ok, overflow_drop, crc_drop;
  logic       m4_valid, m4_last, m4_crc_ok, m4_overflow_drop, m4_crc_drop;
  logic [3:0] frame_count, m4_frame_count;

  int checks = 0;
  int errors = 0;

  btle_rx_pdu_fifo #(.ADDR_WIDTH(8), .FRAME_PTR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .hit_flag(hit_flag), .octet(octet), .octet_valid(octet_valid),
    .decode_end(decode_end), .crc_ok(crc_ok), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_crc_ok(m_crc_ok), .m_ready(m_ready), .frame_count(frame_count),
    .overflow_drop(overflow_drop), .crc_drop(crc_drop)
  );

  btle_rx_pdu_fifo #(.ADDR_WIDTH(4), .FRAME_PTR_WIDTH(3)) dut4 (
    .clk(clk), .rst(rst), .hit_flag(hit_flag), .octet(octet), .octet_valid(octet_valid),
    .decode_end(decode_end), .crc_ok(crc_ok), .m_data(m4_data), .m_valid(m4_valid),
    .m_last(m4_last), .m_crc_ok(m4_crc_ok), .m_ready(m_ready), .frame_count(m4_frame_count),
    .overflow_drop(m4_overflow_drop), .crc_drop(m4_crc_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; m_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic hit;
    hit_flag = 1'b1; tick; hit_flag = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    octet = b; octet_valid = 1'b1; tick; octet_valid = 1'b0;
  endtask

  task automatic finish_frame(input logic c);
    decode_end = 1'b1; crc_ok = c; tick; decode_end = 1'b0; crc_ok = 1'b0;
  endtask

  initial begin
    logic [7:0] t1 [5];
    t1[0] = 8'h40; t1[1] = 8'h03; t1[2] = 8'hAA; t1[3] = 8'hBB; t1[4] = 8'hCC;

    // reset state
    tick; tick;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_crc_ok", m_crc_ok, 0);
    chk("rst_fcount", frame_count, 0);
    chk("rst_ovf", overflow_drop, 0);
    chk("rst_crcdrop", crc_drop, 0);
    rst = 1'b0;
    tick;

    // good frame delivered in order
    hit;
    for (int i = 0; i < 5; i++) push(t1[i]);
    chk("t1_pre_valid", m_valid, 0);
    finish_frame(1'b1);
    chk("t1_fcount", frame_count, 1);
    chk("t1_crc_ok", m_crc_ok, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", m_valid, 1);
      chk("t1_data", m_data, t1[i]);
      chk("t1_last", m_last, (i == 4));
      tick;
    end
    m_ready = 1'b0;
    chk("t1_end_valid", m_valid, 0);
    chk("t1_end_fcount", frame_count, 0);

    // bad CRC frame
    do_reset;
    hit;
    for (int i = 0; i < 5; i++) push(t1[i]);
    finish_frame(1'b0);
`ifdef BTLE_RX_PDU_FIFO_KEEP_BAD_CRC_EN
    chk("t2_crcdrop", crc_drop, 0);
    chk("t2_fcount", frame_count, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_crc_ok", m_crc_ok, 0);
      chk("t2_data", m_data, t1[i]);
      chk("t2_last", m_last, (i == 4));
      tick;
    end
    m_ready = 1'b0;
    chk("t2_end_valid", m_valid, 0);
`else
    chk("t2_crcdrop", crc_drop, 1);
    chk("t2_valid", m_valid, 0);
    chk("t2_fcount", frame_count, 0);
    chk("t2_ovf", overflow_drop, 0);
    tick;
    chk("t2_crcdrop_pulse", crc_drop, 0);
`endif

    // RAM overflow on the 16-octet instance
    do_reset;
    hit;
    for (int i = 0; i < 10; i++) push(8'(i + 1));
    finish_frame(1'b1);
    chk("t3_fcount1", m4_frame_count, 1);
    hit;
    for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
    finish_frame(1'b1);
    chk("t3_ovf", m4_overflow_drop, 1);
    chk("t3_fcount2", m4_frame_count, 1);
    tick;
    chk("t3_ovf_pulse", m4_overflow_drop, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_data", m4_data, i + 1);
      chk("t3_last", m4_last, (i == 9));
      tick;
    end
    m_ready = 1'b0;
    chk("t3_end_valid", m4_valid, 0);

    // abandoned partial frame
    do_reset;
    hit;
    push(8'h55); push(8'h66); push(8'h77);
    hit;
    push(8'h11); push(8'h22);
    finish_frame(1'b1);
    chk("t4_fcount", frame_count, 1);
    m_ready = 1'b1;
    chk("t4_data0", m_data, 8'h11);
    chk("t4_last0", m_last, 0);
    tick;
    chk("t4_data1", m_data, 8'h22);
    chk("t4_last1", m_last, 1);
    tick;
    m_ready = 1'b0;
    chk("t4_end_valid", m_valid, 0);
    chk("t4_end_fcount", frame_count, 0);

    // descriptor FIFO full, then stalled drain
    do_reset;
    for (int k = 0; k < 9; k++) begin
      hit;
      push(8'(8'hA0 + k));
      finish_frame(1'b1);
      chk("t5_ovf", overflow_drop, (k == 8));
    end
    chk("t5_fcount", frame_count, 8);
    for (int k = 0; k < 8; k++) begin
      m_ready = 1'b0;
      tick;
      chk("t5_stall_data", m_data, 8'hA0 + k);
      chk("t5_stall_last", m_last, 1);
      chk("t5_stall_fcount", frame_count, 8 - k);
      m_ready = 1'b1;
      tick;
    end
    m_ready = 1'b0;
    chk("t5_end_valid", m_valid, 0);
    chk("t5_end_fcount", frame_count, 0);

    // pointer wrap on the 16-octet instance
    do_reset;
    for (int it = 0; it < 8; it++) begin
      hit;
      for (int j = 0; j < 5; j++) push(8'((it << 4) | j));
      finish_frame(1'b1);
      m_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
        chk("t6_data", m4_data, (it << 4) | j);
        chk("t6_last", m4_last, (j == 4));
        tick;
      end
      m_ready = 1'b0;
    end
    chk("t6_end_valid", m4_valid, 0);

    // reset in the middle of a read
    hit;
    push(8'h01); push(8'h02); push(8'h03);
    finish_frame(1'b1);
    m_ready = 1'b1;
    tick;
    chk("t7_mid_data", m4_data, 8'h02);
    rst = 1'b1;
    tick;
    chk("t7_valid", m4_valid, 0);
    chk("t7_fcount", m4_frame_count, 0);
    chk("t7_valid_big", m_valid, 0);
    chk("t7_fcount_big", frame_count, 0);
    rst = 1'b0;
    m_ready = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
